execute_mult_sequencer: RTL and testbench
=========================================

// Module: execute_mult_sequencer
// PURPOSE
// - Multi-cycle radix-2 Booth multiply sequencer for the EX stage. It runs MULT/MULTU alongside the single-cycle ALU.
// - Accepts a multiply from ID/EX and asserts stall to freeze IF/ID/EX. It iterates one Booth step per clock.
// - It then presents a 2*WIDTH product on hi/lo for HI/LO write-back.
// PARAMETERS
// - WIDTH  32  operand width in bits; product is 2*WIDTH
// - CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk           in   1      single clock, rising edge
// - rst           in   1      synchronous, active-high reset
// - start         in   1      EX holds MULT/MULTU (ALUOp/funct decoded upstream)
// - signed_op     in   1      1 = MULT (signed), 0 = MULTU (unsigned); sampled with start
// - kill          in   1      synchronous abort (EX flush)
// - multiplicand  in   WIDTH  rs operand (AluReadData1); sampled with start
// - multiplier    in   WIDTH  rt operand (AluReadData2); sampled with start
// - stall         out  1      freeze pipeline (combinational)
// - busy          out  1      registered: state == RUN
// - done          out  1      registered one-cycle pulse; hi/lo valid
// - hi            out  WIDTH  product[2*WIDTH-1:WIDTH]
// - lo            out  WIDTH  product[WIDTH-1:0]
// BEHAVIOUR
// - Reset (clk edge with rst=1): state=IDLE, count=0, done=0, busy=0, hi=0, lo=0. rst overrides kill and start.
// - States
//   - IDLE -> RUN on start & !kill.
//   - RUN -> DONE when count == WIDTH.
//   - DONE -> RUN on start & !kill, else IDLE.
//   - Any state -> IDLE on kill.
// - Operand latch on accept: M, Q are WIDTH+1 bits.
//   - signed_op=1: sign-extend. signed_op=0: zero-extend.
//   - acc=0, q_1=0, count=0.
// - RUN step (one per clock) on {Q[0],q_1}:
//   - 01: acc += M.
//   - 10: acc -= M.
//   - 00/11: no operation.
//   - Then arithmetic-shift {acc,Q,q_1} right 1 (acc MSB replicated); count++.
// - Exactly WIDTH+1 steps. All add/sub is WIDTH+1 bits, overflow discarded.
// - On entering DONE: {hi,lo} <= {acc,Q}[2*WIDTH-1:0].
// - Latency: start accepted in cycle 0 -> done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
// - stall = (state!=RUN & start & !kill) | (state==RUN & !kill).
//   - High from the start cycle through the last RUN cycle; low in the DONE cycle so EX retires.
// - busy tracks RUN; done is high only in DONE.
// - hi/lo hold their value until the next DONE or rst; they are never cleared by kill.
// - start while in RUN: ignored; no restart, no operand resample.
// - start during DONE: accepted back-to-back; done still 1 that cycle.
// - kill mid-RUN: next cycle IDLE, stall=0, no done pulse, hi/lo retain prior result.
// - kill in the same cycle as start: kill wins; request not accepted, stall=0.
// - rst mid-RUN: IDLE next cycle, outputs per reset; no done pulse.
// TESTING
// - Signed 3 x 4, start in cycle 0 -> stall 1 cycles 0..33; done=1 cycle 34 only; hi=0, lo=0x0000000C.
// - Signed 0xFFFFFFFF x 4 (-1 x 4) -> hi=0xFFFFFFFF, lo=0xFFFFFFFC.
// - Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   - Same operands signed -> hi=0, lo=1.
// - Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
//   - Signed 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
// - Abort, then retry:
//   - After a 3 x 4 result, start 7 x 9 and pulse kill in cycle 10 -> stall=0 from cycle 11; no done; hi/lo stay 0/0x0C.
//   - Restart 7 x 9 -> lo=0x3F.
// - Held start, back-to-back and reset:
//   - Hold start high through RUN -> single accept.
//   - Start 2 x 5 in the DONE cycle -> second done 34 cycles later, lo=0x0A.
//   - rst at cycle 5 -> done=0, hi=lo=0, busy=0.

Source files
------------

// File: rtl/execute_mult_sequencer.sv
// -----------------------------------------------------------------------------
// execute_mult_sequencer
//
// Multi-cycle radix-2 Booth multiplier for the EX stage. It handles MULT and
// MULTU next to the single-cycle ALU. When it accepts a request it freezes
// IF/ID/EX through stall. It then performs one Booth step per clock over
// WIDTH+1-bit operands and presents the 2*WIDTH product on hi/lo.
//
// Parameters
//   WIDTH         operand width; the product is 2*WIDTH bits
//   CNT_W         iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; overrides kill and start
//   start         EX holds a MULT/MULTU
//   signed_op     1 = MULT (signed), 0 = MULTU (unsigned); sampled with start
//   kill          synchronous abort (EX flush)
//   multiplicand  rs operand; sampled with start
//   multiplier    rt operand; sampled with start
//   stall         combinational pipeline freeze
//   busy          registered; high while iterating
//   done          registered one-cycle pulse; hi/lo hold the new product
//   hi, lo        upper and lower halves of the product
// -----------------------------------------------------------------------------
module execute_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             kill,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Booth datapath: M, Q and the accumulator are all WIDTH+1 bits wide.
    // The extra bit makes MULTU behave as a signed multiply of zero-extended
    // operands.
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   q_q;
    logic [WIDTH:0]   acc_q;
    logic             q1_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH:0]   q_d;
    logic             q1_d;
    logic             accept_d;
    logic             last_d;

    // One Booth step: add or subtract M based on {Q[0], q_1}. Then shift
    // {acc, Q, q_1} right arithmetically by one bit.
    always_comb begin
        sum_d = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum_d = acc_q + m_q;
            2'b10:   sum_d = acc_q - m_q;
            default: sum_d = acc_q;
        endcase
        acc_d = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH:1]};
        q1_d  = q_q[0];
    end

    // A request is accepted from IDLE or DONE. A kill in the same cycle wins.
    assign accept_d = (state_q != S_RUN) && start && !kill;
    assign last_d   = (count_q == CNT_W'(WIDTH));

    // Stall covers the accept cycle and every RUN cycle. It drops in the DONE
    // cycle so the multiply instruction can retire from EX.
    assign stall = accept_d || ((state_q == S_RUN) && !kill);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Operand and accumulator registers. These are pure data with no reset.
    // They load on accept and step on every RUN cycle.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            m_q   <= {signed_op & multiplicand[WIDTH-1], multiplicand};
            q_q   <= {signed_op & multiplier[WIDTH-1], multiplier};
            acc_q <= '0;
            q1_q  <= 1'b0;
        end else if (state_q == S_RUN) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
        end
    end

    // Control FSM with registered busy/done/hi/lo.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else if (last_d) begin
                        // This is the (WIDTH+1)th step. Capture its shifted
                        // result directly as the product.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hi_q    <= {acc_d[WIDTH-2:0], q_d[WIDTH]};
                        lo_q    <= q_d[WIDTH-1:0];
                    end else begin
                        busy_q  <= 1'b1;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and DONE behave the same way: accept or go idle.
                    if (accept_d) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mult_sequencer.sv
module tb_execute_mult_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_op;
    logic          kill;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          stall;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    execute_mult_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_op    (signed_op),
        .kill         (kill),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Reference product: plain 64-bit multiply of sign- or zero-extended operands
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Behavioural model. An accepted request occupies the unit for WIDTH+1
    // busy cycles, and the result appears with done in the next cycle. A kill
    // during the busy window drops the request.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (kill) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        m_hi   <= m_pend[63:32];
                        m_lo   <= m_pend[31:0];
                    end
                end
            end else if (start && !kill) begin
                m_left <= W + 1;
                m_pend <= ref_prod(multiplicand, multiplier, signed_op);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the current cycle against the model, then advance one clock.
    // Inputs are driven at the negedge and checked 1 time unit later.
    task automatic cyc();
        #1;
        if (chk_en) begin
            chk("cyc_stall", 64'(stall), 64'(!kill && (m_left != 0 || start)));
            chk("cyc_busy",  64'(busy),  64'(m_left != 0));
            chk("cyc_done",  64'(done),  64'(m_done));
            chk("cyc_hi",    64'(hi),    64'(m_hi));
            chk("cyc_lo",    64'(lo),    64'(m_lo));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch a multiply in the current cycle (cycle 0) and wait a bounded time
    // for done. Leaves the bench in the done cycle.
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int lat;
        multiplicand = a;
        multiplier   = b;
        signed_op    = s;
        start        = 1'b1;
        #1;
        chk({tag, "_stall0"}, 64'(stall), 64'd1);
        cyc();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 60) begin
            cyc();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd34);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt[7];

    initial begin
        int ndone;
        vt[0] = '{32'd3,        32'd4,        1'b1, 32'h0000_0000, 32'h0000_000C};
        vt[1] = '{32'hFFFFFFFF, 32'd4,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
        vt[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vt[5] = '{32'h80000000, 32'd1,        1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        vt[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h4000_0000, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; kill = 1'b0; signed_op = 1'b0;
        multiplicand = '0; multiplier = '0;
        @(negedge clk);
        cyc();
        cyc();
        chk_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_hi",    64'(hi),    64'd0);
        chk("rst_lo",    64'(lo),    64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        cyc();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i].a, vt[i].b, vt[i].s, vt[i].ehi, vt[i].elo, $sformatf("vec%0d", i));
            cyc();
        end

        // Abort and retry: 3x4 result, then 7x9 killed in cycle 10
        run_vec(32'd3, 32'd4, 1'b1, 32'h0, 32'hC, "pre_kill");
        cyc();
        multiplicand = 32'd7; multiplier = 32'd9; signed_op = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        kill = 1'b1;
        #1;
        chk("kill_stall10", 64'(stall), 64'd0);
        cyc();
        kill = 1'b0;
        #1;
        chk("kill_stall11", 64'(stall), 64'd0);
        chk("kill_busy11",  64'(busy),  64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            cyc();
        end
        chk("kill_no_done", 64'(ndone), 64'd0);
        chk("kill_hold_hi", 64'(hi), 64'h0);
        chk("kill_hold_lo", 64'(lo), 64'hC);
        run_vec(32'd7, 32'd9, 1'b1, 32'h0, 32'h3F, "retry");
        cyc();

        // Kill in the same cycle as start
        multiplicand = 32'd5; multiplier = 32'd5; start = 1'b1; kill = 1'b1;
        #1;
        chk("skill_stall", 64'(stall), 64'd0);
        cyc();
        start = 1'b0; kill = 1'b0;
        #1;
        chk("skill_busy", 64'(busy), 64'd0);
        cyc();

        // Hold start through RUN while the operands change: single accept
        multiplicand = 32'd5; multiplier = 32'd6; signed_op = 1'b0; start = 1'b1;
        cyc();
        multiplicand = 32'hDEAD_BEEF; multiplier = 32'h1234_5678;
        repeat (33) cyc();
        start = 1'b0;
        #1;
        chk("held_done", 64'(done), 64'd1);
        chk("held_lo",   64'(lo),   64'd30);
        chk("held_hi",   64'(hi),   64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) ndone++;
        end
        chk("held_single", 64'(ndone), 64'd0);

        // Back-to-back: second start in the DONE cycle
        run_vec(32'd3, 32'd4, 1'b1, 32'h0, 32'hC, "b2b_first");
        chk("b2b_done_at_start", 64'(done), 64'd1);
        run_vec(32'd2, 32'd5, 1'b1, 32'h0, 32'h0A, "b2b_second");
        cyc();

        // Reset in the middle of a run
        multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_hi",   64'(hi),   64'd0);
        chk("mrst_lo",   64'(lo),   64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) ndone++;
        end
        chk("mrst_no_done", 64'(ndone), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            kill      = ($urandom_range(0, 60) == 0);
            rst       = ($urandom_range(0, 700) == 0);
            signed_op = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       multiplicand = 32'h8000_0000;
                1:       multiplicand = 32'hFFFF_FFFF;
                2:       multiplicand = 32'h0;
                default: multiplicand = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       multiplier = 32'h8000_0000;
                1:       multiplier = 32'hFFFF_FFFF;
                2:       multiplier = 32'h7FFF_FFFF;
                default: multiplier = $urandom;
            endcase
            cyc();
        end
        start = 1'b0; kill = 1'b0; rst = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
